// File: rtl/rgb_timing_detect.sv
// rgb_timing_detect
//   Measures an incoming hsync/vsync/blank raster (total and active size),
//   locks once the same good measurement repeats over consecutive frames, and
//   then tags every active pixel with its column/row.
//
// Ports
//   i_clk, i_rst_n         pixel clock, async active-low reset
//   i_hsync/i_vsync        syncs, active high
//   i_blank                high outside the active area
//   o_locked               measured timing stable
//   o_total_x/y, o_res_x/y locked measurement (held across lock loss)
//   o_active, o_x, o_y     per-pixel active flag and coordinates (2-clock latency)
//   o_frame_start          one-cycle pulse per vsync rising edge
module rgb_timing_detect #(
  parameter int P_CNT_W       = 12,
  parameter int P_LOCK_FRAMES = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_hsync,
  input  logic               i_vsync,
  input  logic               i_blank,
  output logic               o_locked,
  output logic [P_CNT_W-1:0] o_total_x,
  output logic [P_CNT_W-1:0] o_total_y,
  output logic [P_CNT_W-1:0] o_res_x,
  output logic [P_CNT_W-1:0] o_res_y,
  output logic               o_active,
  output logic [P_CNT_W-1:0] o_x,
  output logic [P_CNT_W-1:0] o_y,
  output logic               o_frame_start
);

  localparam logic [P_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [P_CNT_W-1:0] ONE     = P_CNT_W'(1);

  typedef enum logic [1:0] {S_SEARCH, S_CHECK, S_LOCKED} state_t;

  typedef struct packed {
    logic [P_CNT_W-1:0] total_x;
    logic [P_CNT_W-1:0] total_y;
    logic [P_CNT_W-1:0] res_x;
    logic [P_CNT_W-1:0] res_y;
  } meas_t;

  // input stage: q = registered inputs, qq = one more stage for edge detect
  logic hs_q, vs_q, bl_q, hs_qq, vs_qq, bl_qq;
  logic hs_rise, vs_rise, act_start, act_end;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      {hs_q, vs_q, bl_q}    <= '0;
      {hs_qq, vs_qq, bl_qq} <= '0;
    end else begin
      {hs_q, vs_q, bl_q}    <= {i_hsync, i_vsync, i_blank};
      {hs_qq, vs_qq, bl_qq} <= {hs_q, vs_q, bl_q};
    end
  end

  assign hs_rise   = hs_q & ~hs_qq;
  assign vs_rise   = vs_q & ~vs_qq;
  assign act_start = ~bl_q & bl_qq;
  assign act_end   = bl_q & ~bl_qq;

  // measurement counters
  logic [P_CNT_W-1:0] h_cnt, a_cnt, line_cnt, act_lines, line_len, width;
  logic [P_CNT_W-1:0] first_len, first_wid;
  logic               len_vld, wid_vld, frame_bad;

  logic               h_sat, a_sat, l_sat, al_sat, timeout, bad_n;
  logic [P_CNT_W-1:0] line_len_n, line_cnt_n, width_n, act_lines_n;
  meas_t              meas;

  // *_n values fold in an edge landing in the same cycle as vs_rise, so a
  // line/active-line ending on the frame boundary counts in the ending frame.
  always_comb begin
    h_sat       = (h_cnt == CNT_MAX);
    a_sat       = (a_cnt == CNT_MAX);
    l_sat       = (line_cnt == CNT_MAX);
    al_sat      = (act_lines == CNT_MAX);
    line_len_n  = hs_rise ? h_cnt + ONE : line_len;
    line_cnt_n  = (hs_rise && !l_sat) ? line_cnt + ONE : line_cnt;
    width_n     = act_end ? a_cnt : width;
    act_lines_n = (act_end && !al_sat) ? act_lines + ONE : act_lines;
    bad_n       = frame_bad | h_sat | a_sat | l_sat | al_sat
                | (hs_rise & len_vld & (line_len_n != first_len))
                | (act_end & wid_vld & (a_cnt != first_wid));
    meas        = '{total_x: line_len_n, total_y: line_cnt_n,
                    res_x: width_n, res_y: act_lines_n};
    // a fresh hs_rise ends the stall, so resumed video is not swallowed
    timeout     = h_sat & ~hs_rise;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_cnt     <= '0;
      a_cnt     <= '0;
      line_cnt  <= '0;
      act_lines <= '0;
      line_len  <= '0;
      width     <= '0;
      first_len <= '0;
      first_wid <= '0;
      len_vld   <= 1'b0;
      wid_vld   <= 1'b0;
      frame_bad <= 1'b0;
    end else begin
      if (hs_rise)     h_cnt <= '0;
      else if (!h_sat) h_cnt <= h_cnt + ONE;

      if (act_end)              a_cnt <= '0;
      else if (!bl_q && !a_sat) a_cnt <= a_cnt + ONE;

      line_len <= line_len_n;
      width    <= width_n;

      if (vs_rise) begin
        line_cnt  <= '0;
        act_lines <= '0;
        frame_bad <= 1'b0;
        len_vld   <= 1'b0;
        wid_vld   <= 1'b0;
      end else begin
        line_cnt  <= line_cnt_n;
        act_lines <= act_lines_n;
        frame_bad <= bad_n;
        if (hs_rise && !len_vld) begin
          first_len <= line_len_n;
          len_vld   <= 1'b1;
        end
        if (act_end && !wid_vld) begin
          first_wid <= a_cnt;
          wid_vld   <= 1'b1;
        end
      end
    end
  end

  // lock FSM
  state_t     state, state_n;
  meas_t      cand, cand_n;
  logic       cand_vld, cand_vld_n, locked_n, lock_load, match;
  logic [3:0] match_cnt, match_n;

  always_comb begin
    state_n    = state;
    cand_n     = cand;
    cand_vld_n = cand_vld;
    match_n    = match_cnt;
    locked_n   = o_locked;
    lock_load  = 1'b0;
    match      = cand_vld && (meas == cand);
    if (timeout) begin
      state_n    = S_SEARCH;
      locked_n   = 1'b0;
      cand_vld_n = 1'b0;
      match_n    = '0;
    end else if (vs_rise) begin
      unique case (state)
        S_SEARCH: begin
          // first edge only opens a clean measurement window
          state_n    = S_CHECK;
          cand_vld_n = 1'b0;
          match_n    = '0;
        end
        S_CHECK: begin
          if (!match || bad_n) begin
            cand_n     = meas;
            cand_vld_n = !bad_n;
            match_n    = '0;
          end else begin
            match_n = match_cnt + 4'd1;
            if (match_n == 4'(P_LOCK_FRAMES)) begin
              lock_load = 1'b1;
              locked_n  = 1'b1;
              state_n   = S_LOCKED;
            end
          end
        end
        S_LOCKED: begin
          if (!match || bad_n) begin
            locked_n   = 1'b0;
            cand_n     = meas;
            cand_vld_n = !bad_n;
            match_n    = '0;
            state_n    = S_CHECK;
          end
        end
        default: state_n = S_SEARCH;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_SEARCH;
      cand      <= '0;
      cand_vld  <= 1'b0;
      match_cnt <= '0;
      o_locked  <= 1'b0;
      o_total_x <= '0;
      o_total_y <= '0;
      o_res_x   <= '0;
      o_res_y   <= '0;
    end else begin
      state     <= state_n;
      cand      <= cand_n;
      cand_vld  <= cand_vld_n;
      match_cnt <= match_n;
      o_locked  <= locked_n;
      if (lock_load) begin
        o_total_x <= cand.total_x;
        o_total_y <= cand.total_y;
        o_res_x   <= cand.res_x;
        o_res_y   <= cand.res_y;
      end
    end
  end

  // coordinates; act_lines already equals the active-row index mid-line
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_active      <= 1'b0;
      o_x           <= '0;
      o_y           <= '0;
      o_frame_start <= 1'b0;
    end else begin
      o_frame_start <= vs_rise;
      o_active      <= o_locked & ~bl_q;
      if (!o_locked) begin
        o_x <= '0;
        o_y <= '0;
      end else if (!bl_q) begin
        o_x <= act_start ? '0 : o_x + ONE;
        o_y <= act_lines;
      end
    end
  end

endmodule

// File: tb/tb_rgb_timing_detect.sv
// Bench for rgb_timing_detect: random small rasters driven pixel by pixel,
// expectations from a frame-level lock model plus per-pixel raster geometry.
module tb_rgb_timing_detect;
  localparam int W  = 12;
  localparam int LF = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  logic hsync = 1'b0, vsync = 1'b0, blank = 1'b1;
  logic locked, active, frame_start;
  logic [W-1:0] total_x, total_y, res_x, res_y, x, y;

  rgb_timing_detect #(.P_CNT_W(W), .P_LOCK_FRAMES(LF)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_hsync(hsync), .i_vsync(vsync),
    .i_blank(blank), .o_locked(locked), .o_total_x(total_x),
    .o_total_y(total_y), .o_res_x(res_x), .o_res_y(res_y),
    .o_active(active), .o_x(x), .o_y(y), .o_frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct { int tx, ty, rx, ry, hsw, hbp, vsw, vbp; } tim_t;
  typedef struct {
    bit lkck, lk, act, fs, dims, zchk;
    int x, y, tx, ty, rx, ry;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0, n_err = 0, cyc = 0, last_hs = 0;

  // frame-level model: lock = last LF+1 good measured frames identical
  bit   started = 0, m_lk = 0, pend_bad = 0;
  int   run = 0;
  tim_t pend, last;
  int   h_tx = 0, h_ty = 0, h_rx = 0, h_ry = 0;

  function automatic bit same_dims(input tim_t a, input tim_t b);
    return a.tx == b.tx && a.ty == b.ty && a.rx == b.rx && a.ry == b.ry;
  endfunction

  task automatic model_reset(input bit clr_dims);
    started = 0; run = 0; m_lk = 0;
    if (clr_dims) begin h_tx = 0; h_ty = 0; h_rx = 0; h_ry = 0; end
  endtask

  task automatic frame_edge();
    if (!started) begin
      started = 1; run = 0;
    end else begin
      if (pend_bad)                              run = 0;
      else if (run > 0 && same_dims(pend, last)) run++;
      else                                       run = 1;
      if (!pend_bad) last = pend;
      if (run >= LF + 1) begin
        h_tx = last.tx; h_ty = last.ty; h_rx = last.rx; h_ry = last.ry;
      end
    end
    m_lk = (run >= LF + 1);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_exp(input exp_t e);
    if (e.lkck) chk("locked", locked, e.lk);
    chk("active", active, e.act);
    chk("frame_start", frame_start, e.fs);
    if (e.act) begin
      chk("x", x, e.x);
      chk("y", y, e.y);
    end else if (e.zchk) begin
      chk("x_unlocked", x, 0);
      chk("y_unlocked", y, 0);
    end
    if (e.dims) begin
      chk("total_x", total_x, e.tx);
      chk("total_y", total_y, e.ty);
      chk("res_x", res_x, e.rx);
      chk("res_y", res_y, e.ry);
    end
  endtask

  // outputs for the pixel driven at step s are checked at step s+2
  task automatic step(input logic hs, input logic vs, input logic bl, input exp_t e);
    @(negedge clk);
    if (q.size() >= 2) check_exp(q.pop_front());
    hsync = hs; vsync = vs; blank = bl;
    q.push_back(e);
    cyc++;
  endtask

  task automatic idle(input int n, input bit lkck);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e = '{default: 0};
      e.lkck = lkck; e.lk = m_lk; e.zchk = lkck && !m_lk;
      step(1'b0, 1'b0, 1'b1, e);
    end
  endtask

  function automatic tim_t rand_tim();
    tim_t t;
    t.hsw = $urandom_range(1, 3); t.hbp = $urandom_range(1, 4);
    t.rx  = $urandom_range(4, 16);
    t.tx  = t.hsw + t.hbp + t.rx + $urandom_range(1, 4);
    t.vsw = $urandom_range(1, 2); t.vbp = $urandom_range(1, 2);
    t.ry  = $urandom_range(3, 10);
    t.ty  = t.vsw + t.vbp + t.ry + $urandom_range(1, 2);
    return t;
  endfunction

  // raster order: sync, back porch, active, front porch (both axes), so a
  // frame starts with hsync and vsync rising together
  task automatic drive_frame(input tim_t t, input int short_ln, input int limit);
    exp_t e;
    bit   ax, ay;
    int   n  = 0;
    int   ax0 = t.hsw + t.hbp;
    int   ay0 = t.vsw + t.vbp;
    frame_edge();
    for (int yy = 0; yy < t.ty; yy++) begin
      for (int xx = 0; xx < t.tx; xx++) begin
        if (limit >= 0 && n >= limit) return;
        ay = (yy >= ay0) && (yy < ay0 + t.ry);
        ax = (xx >= ax0) && (xx < ax0 + t.rx - (((yy - ay0) == short_ln) ? 1 : 0));
        e = '{default: 0};
        e.lkck = 1; e.lk = m_lk; e.act = m_lk && ax && ay;
        e.x = xx - ax0; e.y = yy - ay0;
        e.fs = (xx == 0 && yy == 0); e.dims = e.fs;
        e.tx = h_tx; e.ty = h_ty; e.rx = h_rx; e.ry = h_ry;
        e.zchk = !m_lk && yy >= 1;
        if (xx == 0) last_hs = cyc;
        step(xx < t.hsw, yy < t.vsw, !(ax && ay), e);
        n++;
      end
    end
    pend = t; pend_bad = (short_ln >= 0);
  endtask

  task automatic chk_dims(input string tag, input tim_t t);
    chk({tag, "_locked"}, locked, 1);
    chk({tag, "_total_x"}, total_x, t.tx);
    chk({tag, "_total_y"}, total_y, t.ty);
    chk({tag, "_res_x"}, res_x, t.rx);
    chk({tag, "_res_y"}, res_y, t.ry);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    tim_t ta, tb2;
    int   c, lim;
    model_reset(1);
    repeat (2) @(negedge clk);
    chk("rst_locked", locked, 0);  chk("rst_active", active, 0);
    chk("rst_fs", frame_start, 0); chk("rst_x", x, 0); chk("rst_y", y, 0);
    chk("rst_total_x", total_x, 0); chk("rst_res_y", res_y, 0);
    rst_n = 1'b1;
    idle(3, 1);

    // lock on first timing
    ta = rand_tim();
    for (int i = 0; i < 6; i++) drive_frame(ta, -1, -1);
    chk_dims("lock_a", ta);

    // switch to a different timing at a frame boundary
    do tb2 = rand_tim(); while (same_dims(ta, tb2));
    for (int i = 0; i < 5; i++) drive_frame(tb2, -1, -1);
    chk_dims("lock_b", tb2);

    // one short active line, then good frames
    drive_frame(tb2, $urandom_range(0, tb2.ry - 1), -1);
    for (int i = 0; i < 4; i++) drive_frame(tb2, -1, -1);
    chk_dims("relock_short", tb2);

    // hsync stall: timeout ~4096 clocks after the last hsync rise
    while (cyc - last_hs <= 4110) begin
      exp_t e;
      e = '{default: 0};
      c = cyc;
      step(1'b0, 1'b0, 1'b1, e);
      if (c - last_hs == 4090) chk("timeout_hold", locked, 1);
      if (c - last_hs == 4105) chk("timeout_drop", locked, 0);
    end
    chk("timeout_keep_total_x", total_x, tb2.tx);
    model_reset(0);
    for (int i = 0; i < 5; i++) drive_frame(ta, -1, -1);
    chk_dims("relock_timeout", ta);

    // asynchronous reset in the middle of an active line
    lim = (ta.vsw + ta.vbp + 1) * ta.tx + ta.hsw + ta.hbp + 4;
    drive_frame(ta, -1, lim);
    chk("pre_rst_active", active, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_locked", locked, 0);   chk("arst_active", active, 0);
    chk("arst_x", x, 0);             chk("arst_y", y, 0);
    chk("arst_total_x", total_x, 0); chk("arst_total_y", total_y, 0);
    chk("arst_res_x", res_x, 0);     chk("arst_res_y", res_y, 0);
    q.delete();
    model_reset(1);
    hsync = 1'b0; vsync = 1'b0; blank = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(3, 1);
    for (int i = 0; i < 6; i++) drive_frame(ta, -1, -1);
    chk_dims("relock_reset", ta);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
